// File: rtl/dsm_mod1_if.sv
// dsm_mod1_if: sample handshake and modulator output bundle for dsm_mod1
// master (stimulus side) drives en, din, din_valid
// slave (modulator) drives din_ready, dout, dout_valid, sample_req, underrun, acc_out
interface dsm_mod1_if #(parameter int WIDTH = 8);
  logic en;
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic dout;
  logic dout_valid;
  logic sample_req;
  logic underrun;
  logic [WIDTH-1:0] acc_out;
  modport master(output en, din, din_valid,
                 input din_ready, dout, dout_valid, sample_req, underrun, acc_out);
  modport slave(input en, din, din_valid,
                output din_ready, dout, dout_valid, sample_req, underrun, acc_out);
endinterface

// File: rtl/dsm_mod1.sv
// dsm_mod1: first-order delta-sigma modulator, WIDTH-bit samples to a 1-bit stream
// clk, rst: rising-edge clock, synchronous active-high reset
// bus: en, din/din_valid/din_ready handshake into a one-deep buffer,
//      dout/dout_valid bitstream, sample_req boundary pulse, sticky underrun, acc_out debug
module dsm_mod1 #(
  parameter int WIDTH = 8,
  parameter int OSR = 64
) (
  input logic clk,
  input logic rst,
  dsm_mod1_if.slave bus
);
  localparam int PW = $clog2(OSR);
  logic [WIDTH-1:0] acc, active, hold, sum;
  logic [WIDTH:0] c;
  logic [PW-1:0] phase;
  logic hold_full, boundary, dout, dout_valid, sample_req, underrun;
  // ripple chain of full-adder cells; carry out of the MSB is the modulated bit
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = acc[i] ^ active[i] ^ c[i];
    assign c[i+1] = (acc[i] & active[i]) | (c[i] & (acc[i] ^ active[i]));
  end
  assign boundary = bus.en && phase == PW'(OSR - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      active <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      phase <= '0;
      dout <= 1'b0;
      dout_valid <= 1'b0;
      sample_req <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dout_valid <= bus.en;
      sample_req <= boundary;
      if (bus.en) begin
        acc <= sum;
        dout <= c[WIDTH];
        phase <= boundary ? '0 : phase + 1'b1;
      end
      // a full buffer drains at the boundary; an empty one repeats the last sample
      if (boundary) begin
        if (hold_full) begin
          active <= hold;
          hold_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
      // accept only into an empty buffer, so a draining boundary never also accepts
      if (bus.din_valid && !hold_full) begin
        hold <= bus.din;
        hold_full <= 1'b1;
      end
    end
  end
  assign bus.din_ready = !hold_full;
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.sample_req = sample_req;
  assign bus.underrun = underrun;
  assign bus.acc_out = acc;
endmodule

// File: tb/tb_dsm_mod1.sv
// tb_dsm_mod1: directed checks of dsm_mod1 at WIDTH=8/OSR=256 and WIDTH=4/OSR=16
module tb_dsm_mod1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int w_ones, w_reqs, w_first;
  logic [7:0] w_acc [4];
  always #5 clk = ~clk;
  dsm_mod1_if #(.WIDTH(8)) b8();
  dsm_mod1_if #(.WIDTH(4)) b4();
  dsm_mod1 #(.WIDTH(8), .OSR(256)) u8(.clk(clk), .rst(rst), .bus(b8));
  dsm_mod1 #(.WIDTH(4), .OSR(16)) u4(.clk(clk), .rst(rst), .bus(b4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one 256-edge window; optionally offers nxt on its first edge and pauses en for 10 cycles
  task automatic window(input logic [7:0] nxt, input bit give, input int pause_at);
    logic [7:0] a;
    w_ones = 0;
    w_reqs = 0;
    w_first = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == pause_at) begin
        a = b8.acc_out;
        b8.en = 1'b0;
        repeat (10) tick();
        chk("pause_dout_valid", 32'(b8.dout_valid), 0);
        chk("pause_acc", 32'(b8.acc_out), 32'(a));
        chk("pause_sample_req", 32'(b8.sample_req), 0);
      end
      b8.en = 1'b1;
      b8.din = nxt;
      b8.din_valid = give && i == 0;
      tick();
      b8.din_valid = 1'b0;
      w_ones += 32'(b8.dout);
      w_reqs += 32'(b8.sample_req);
      if (b8.dout && w_first == 0) w_first = i + 1;
      if (i < 4) w_acc[i] = b8.acc_out;
    end
    b8.en = 1'b0;
  endtask
  initial begin
    int ones, acc_cnt;
    logic [3:0] exp4;
    logic [3:0] q [$];
    b8.en = 1'b0;
    b8.din = '0;
    b8.din_valid = 1'b0;
    b4.en = 1'b0;
    b4.din = '0;
    b4.din_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_acc", 32'(b8.acc_out), 0);
    chk("rst_dout", 32'(b8.dout), 0);
    chk("rst_dout_valid", 32'(b8.dout_valid), 0);
    chk("rst_sample_req", 32'(b8.sample_req), 0);
    chk("rst_underrun", 32'(b8.underrun), 0);
    chk("rst_din_ready", 32'(b8.din_ready), 1);
    rst = 1'b0;
    b8.din = 8'h40;
    b8.din_valid = 1'b1;
    tick();
    chk("accept_ready_drop", 32'(b8.din_ready), 0);
    b8.din = 8'h99;
    tick();
    b8.din_valid = 1'b0;
    chk("ignored_while_full", 32'(b8.din_ready), 0);
    chk("en_low_dout_valid", 32'(b8.dout_valid), 0);
    window(8'h00, 1'b0, -1);
    chk("w1_ones", 32'(w_ones), 0);
    chk("w1_reqs", 32'(w_reqs), 1);
    chk("w1_req_at_256", 32'(b8.sample_req), 1);
    chk("w1_underrun", 32'(b8.underrun), 0);
    chk("w1_acc_old_active", 32'(b8.acc_out), 0);
    chk("w1_ready_after_swap", 32'(b8.din_ready), 1);
    window(8'hFF, 1'b1, -1);
    chk("w2_acc0", 32'(w_acc[0]), 32'h40);
    chk("w2_acc1", 32'(w_acc[1]), 32'h80);
    chk("w2_acc2", 32'(w_acc[2]), 32'hC0);
    chk("w2_acc3", 32'(w_acc[3]), 32'h00);
    chk("w2_first_one_260", 32'(w_first), 4);
    chk("w2_ones", 32'(w_ones), 64);
    chk("w2_underrun", 32'(b8.underrun), 0);
    window(8'h00, 1'b1, -1);
    chk("w3_swap_acc0", 32'(w_acc[0]), 32'hFF);
    chk("w3_ones", 32'(w_ones), 255);
    window(8'h30, 1'b1, -1);
    chk("w4_ones", 32'(w_ones), 0);
    chk("w4_underrun", 32'(b8.underrun), 0);
    window(8'h00, 1'b0, -1);
    chk("w5_ones", 32'(w_ones), 48);
    chk("w5_underrun_set", 32'(b8.underrun), 1);
    window(8'hA3, 1'b1, -1);
    chk("w6_repeat_ones", 32'(w_ones), 48);
    chk("w6_underrun_sticky", 32'(b8.underrun), 1);
    window(8'h00, 1'b0, 100);
    chk("w7_paused_ones", 32'(w_ones), 163);
    chk("w7_paused_reqs", 32'(w_reqs), 1);
    chk("w7_underrun_sticky", 32'(b8.underrun), 1);
    b8.en = 1'b1;
    b8.din = 8'h55;
    b8.din_valid = 1'b1;
    tick();
    chk("pre_rst_acc", 32'(b8.acc_out), 32'hA3);
    chk("pre_rst_full", 32'(b8.din_ready), 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_acc", 32'(b8.acc_out), 0);
    chk("mid_rst_dout", 32'(b8.dout), 0);
    chk("mid_rst_din_ready", 32'(b8.din_ready), 1);
    chk("mid_rst_underrun", 32'(b8.underrun), 0);
    chk("mid_rst_sample_req", 32'(b8.sample_req), 0);
    chk("mid_rst_dout_valid", 32'(b8.dout_valid), 0);
    rst = 1'b0;
    b8.en = 1'b0;
    b8.din_valid = 1'b0;
    b4.en = 1'b1;
    b4.din_valid = 1'b1;
    exp4 = 4'h0;
    for (int w = 0; w < 10; w++) begin
      ones = 0;
      acc_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        b4.din = 4'($urandom_range(0, 15));
        if (b4.din_ready) begin
          q.push_back(b4.din);
          acc_cnt++;
        end
        tick();
        ones += 32'(b4.dout);
      end
      chk($sformatf("w4b_%0d_ones", w), 32'(ones), 32'(exp4));
      chk($sformatf("w4b_%0d_one_accept", w), 32'(acc_cnt), 1);
      if (q.size() > 0) exp4 = q.pop_front();
    end
    chk("w4b_underrun", 32'(b4.underrun), 0);
    b4.en = 1'b0;
    b4.din_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dsm_mod1.md
Name: dsm_mod1

Overview:
- First-order digital delta-sigma modulator. Converts a WIDTH-bit unsigned sample stream into a 1-bit oversampled bitstream.
- Core is a WIDTH-bit ripple accumulator built from the team's full-adder cell chain. The carry out of the MSB is the output bit.
- Sits directly downstream of the FA/adder primitive and upstream of the 1-bit DAC/decimation path.
- Input samples arrive through a valid/ready handshake into a one-deep holding buffer. The buffer is swapped into the active register once per OSR cycles.

Parameters:
WIDTH  8   accumulator and sample width, unsigned; legal range 2..16
OSR    64  enabled clock cycles per input sample; legal range 2..2^16

Ports:
clk         in   1      single system clock, rising edge
rst         in   1      synchronous, active-high reset
en          in   1      clock enable for modulation; low freezes all modulation state
din         in   WIDTH  unsigned input sample
din_valid   in   1      din is valid this cycle
din_ready   out  1      holding buffer empty; accept when din_valid & din_ready
dout        out  1      modulated bit, registered
dout_valid  out  1      dout updated this cycle
sample_req  out  1      one-cycle pulse at each sample boundary
underrun    out  1      sticky: a boundary occurred with holding buffer empty
acc_out     out  WIDTH  current accumulator value (debug/verification)

Behaviour:
- Reset, applied on clk edge with rst=1:
  - acc=0, active=0, hold=0, hold_full=0, phase=0.
  - dout=0, dout_valid=0, sample_req=0, underrun=0, din_ready=1.
  - rst has priority over every other input, including mid-sample and at a boundary.
- din_ready = !hold_full, registered-state derived with no combinational path from din_valid.
- Accept: din_valid & din_ready at an edge → hold<=din, hold_full<=1. din_valid while ready=0 is ignored, with no error flag.
- Accumulate, on each edge with en=1:
  - {c, acc} <= acc + active. This is a (WIDTH+1)-bit sum; acc wraps modulo 2^WIDTH.
  - dout<=c and dout_valid<=1.
- Edge with en=0: acc, dout and phase hold; dout_valid<=0; sample_req<=0. Handshake acceptance still operates.
- Phase counter, clog2(OSR) bits wide:
  - Increments on en edges and wraps from OSR-1 to 0.
  - The boundary is an en edge with phase==OSR-1.
- At a boundary:
  - sample_req<=1 for exactly one cycle.
  - If hold_full: active<=hold, hold_full<=0.
  - If not hold_full: active is unchanged (last sample repeats) and underrun<=1.
- The addition in the boundary cycle uses the old active. The new sample contributes from the next en edge.
- Simultaneous boundary and din_valid with hold_full=1: the transfer happens and the new word is NOT accepted that cycle. din_ready rises the following cycle.
- Simultaneous boundary and din_valid with hold_full=0: din is accepted into hold and underrun is set. The new word becomes active at the next boundary.
- Density: for constant active=x starting from acc=0, exactly x ones appear in any 2^WIDTH consecutive en cycles. x=0 gives all zeros; x=2^WIDTH-1 gives one zero per 2^WIDTH cycles.
- underrun clears only on rst.
- acc_out = acc register.

Test Plan:
1. WIDTH=8, OSR=256. Reset, present din=0x40 with valid at cycle 1 → din_ready drops. Then 256 en cycles with dout=0 and underrun=0. sample_req pulses on en edge 256. Following cycles: dout=1 on every 4th en edge, with the first at edge 260; exactly 64 ones in edges 257..512; acc_out sequence 0x40,0x80,0xC0,0x00.
2. Same config, din=0xFF then din=0x00 at successive boundaries → 255 ones in the first active window, 0 ones in the second. Sample-boundary swap is visible exactly one edge after sample_req.
3. No new sample supplied before a boundary → underrun=1 and stays 1. Active value repeats, so the ones-count of the next window equals the prior window.
4. Toggle en low for 10 cycles mid-window → dout_valid=0, acc_out and phase frozen. The ones count over the window is unchanged versus an uninterrupted run.
5. Assert rst mid-window with acc=0xA3 and hold_full=1 → next cycle acc_out=0, dout=0, din_ready=1, underrun=0, sample_req=0.
6. din_valid held high continuously with random din (WIDTH=4, OSR=16) → at most one acceptance per boundary. No accepted word is lost. Ones per 16-cycle window equals that window's active value.
